// File: rtl/call_scheduler_if.sv
// Button/lamp/control bundle between the call scheduler and its neighbours.
//   master : drives buttons, floor, arrived, served; observes dir, stop_here, lamps
//   slave  : the scheduler itself
interface call_scheduler_if #(parameter int FLOORS = 4);
    logic [FLOORS-2:0] out_up;     // hall up buttons, bit i = floor i
    logic [FLOORS-2:0] out_down;   // hall down buttons, bit i-1 = floor i
    logic [FLOORS-1:0] in_num;     // cabin buttons
    logic [FLOORS-1:0] floor;      // one-hot current floor
    logic              arrived;    // car level with a floor while moving
    logic              served;     // door opened, calls at this floor served
    logic [1:0]        dir;        // 00 idle, 01 up, 10 down
    logic              stop_here;  // controller must stop and open the door
    logic [FLOORS-2:0] up_lamp;
    logic [FLOORS-2:0] down_lamp;
    logic [FLOORS-1:0] in_lamp;

    modport master (
        output out_up, out_down, in_num, floor, arrived, served,
        input  dir, stop_here, up_lamp, down_lamp, in_lamp
    );

    modport slave (
        input  out_up, out_down, in_num, floor, arrived, served,
        output dir, stop_here, up_lamp, down_lamp, in_lamp
    );
endinterface

// File: rtl/call_scheduler.sv
// SCAN (collective) elevator call scheduler.
// Latches hall up/down and cabin calls, drives the lamps from the latched
// calls, chooses travel direction and flags floors where the car must stop.
// Ports:
//   clk  - system clock, posedge
//   rst  - synchronous active-high reset
//   bus  - call_scheduler_if.slave (buttons, floor, arrived/served in;
//          dir, stop_here, lamps out)
module call_scheduler #(
    parameter int FLOORS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    call_scheduler_if.slave        bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_SERVE = 3'd3,
        ST_EVAL  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SVC_NONE = 2'b00,
        SVC_UP   = 2'b01,
        SVC_DOWN = 2'b10
    } svc_t;

    localparam logic [FLOORS-1:0] ONE_V  = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FLOORS-1:0] ZERO_V = {FLOORS{1'b0}};

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [FLOORS-1:0] v);
        return (v != ZERO_V) && ((v & (v - ONE_V)) == ZERO_V);
    endfunction

    logic [FLOORS-2:0] up_req_r;
    logic [FLOORS-2:0] down_req_r;
    logic [FLOORS-1:0] in_req_r;
    state_t            state_r, state_nxt_s;
    svc_t              svc_dir_r, svc_dir_nxt_s;
    logic [1:0]        dir_r, dir_nxt_s;
    logic              stop_here_r;

    logic [FLOORS-1:0] up_full_s, down_full_s, all_req_s;
    logic [FLOORS-1:0] below_mask_s, above_mask_s;
    logic [FLOORS-1:0] clr_in_s, clr_up_s, clr_down_s;
    logic              floor_ok_s, any_above_s, any_below_s;
    logic              up_here_s, down_here_s, in_here_s, here_any_s;
    logic              serve_clr_s;
    svc_t              svc_pick_s;

    // Floor-relative request summary; up/down vectors widened to one bit per floor
    // (the missing top-up and bottom-down bits read as zero).
    always_comb begin
        up_full_s    = {1'b0, up_req_r};
        down_full_s  = {down_req_r, 1'b0};
        all_req_s    = in_req_r | up_full_s | down_full_s;
        floor_ok_s   = is_onehot(bus.floor);
        below_mask_s = bus.floor - ONE_V;
        above_mask_s = ~(bus.floor | below_mask_s);
        any_above_s  = |(all_req_s & above_mask_s);
        any_below_s  = |(all_req_s & below_mask_s);
        up_here_s    = |(up_full_s & bus.floor);
        down_here_s  = |(down_full_s & bus.floor);
        in_here_s    = |(in_req_r & bus.floor);
        here_any_s   = up_here_s | down_here_s | in_here_s;
        if (up_here_s) begin
            svc_pick_s = SVC_UP;
        end else if (down_here_s) begin
            svc_pick_s = SVC_DOWN;
        end else begin
            svc_pick_s = SVC_NONE;
        end
    end

    // Per-floor clear masks, only on a served pulse while serving a valid floor.
    always_comb begin
        serve_clr_s = bus.served && (state_r == ST_SERVE) && floor_ok_s;
        clr_in_s    = serve_clr_s ? bus.floor : ZERO_V;
        clr_up_s    = (serve_clr_s && (svc_dir_r == SVC_UP))   ? bus.floor : ZERO_V;
        clr_down_s  = (serve_clr_s && (svc_dir_r == SVC_DOWN)) ? bus.floor : ZERO_V;
    end

    // Request registers: set by buttons, clear has priority in the served cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_req_r   <= {(FLOORS-1){1'b0}};
            down_req_r <= {(FLOORS-1){1'b0}};
            in_req_r   <= ZERO_V;
        end else begin
            up_req_r   <= (up_req_r   | bus.out_up)   & ~clr_up_s[FLOORS-2:0];
            down_req_r <= (down_req_r | bus.out_down) & ~clr_down_s[FLOORS-1:1];
            in_req_r   <= (in_req_r   | bus.in_num)   & ~clr_in_s;
        end
    end

    // SCAN next-state and service-direction selection; frozen while floor is invalid.
    always_comb begin
        state_nxt_s   = state_r;
        svc_dir_nxt_s = svc_dir_r;
        if (!floor_ok_s) begin
            state_nxt_s   = state_r;
            svc_dir_nxt_s = svc_dir_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (here_any_s) begin
                        state_nxt_s   = ST_SERVE;
                        svc_dir_nxt_s = svc_pick_s;
                    end else if (any_above_s) begin
                        state_nxt_s = ST_UP;
                    end else if (any_below_s) begin
                        state_nxt_s = ST_DOWN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_UP: begin
                    if (!bus.arrived) begin
                        state_nxt_s = ST_UP;
                    end else if (in_here_s || up_here_s || (!any_above_s && down_here_s)) begin
                        state_nxt_s   = ST_SERVE;
                        svc_dir_nxt_s = (up_here_s || any_above_s) ? SVC_UP : SVC_DOWN;
                    end else if (!any_above_s) begin
                        state_nxt_s = ST_EVAL;
                    end else begin
                        state_nxt_s = ST_UP;
                    end
                end
                ST_DOWN: begin
                    if (!bus.arrived) begin
                        state_nxt_s = ST_DOWN;
                    end else if (in_here_s || down_here_s || (!any_below_s && up_here_s)) begin
                        state_nxt_s   = ST_SERVE;
                        svc_dir_nxt_s = (down_here_s || any_below_s) ? SVC_DOWN : SVC_UP;
                    end else if (!any_below_s) begin
                        state_nxt_s = ST_EVAL;
                    end else begin
                        state_nxt_s = ST_DOWN;
                    end
                end
                ST_SERVE: begin
                    if (bus.served) begin
                        state_nxt_s = ST_EVAL;
                    end else begin
                        state_nxt_s = ST_SERVE;
                    end
                end
                ST_EVAL: begin
                    // Keep sweeping in the served direction before reconsidering.
                    if ((svc_dir_r == SVC_UP) && any_above_s) begin
                        state_nxt_s = ST_UP;
                    end else if ((svc_dir_r == SVC_DOWN) && any_below_s) begin
                        state_nxt_s = ST_DOWN;
                    end else if (here_any_s) begin
                        state_nxt_s   = ST_SERVE;
                        svc_dir_nxt_s = svc_pick_s;
                    end else if (any_above_s) begin
                        state_nxt_s = ST_UP;
                    end else if (any_below_s) begin
                        state_nxt_s = ST_DOWN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    svc_dir_nxt_s = SVC_NONE;
                end
            endcase
        end
    end

    // Direction code of the current state; registered below so outputs trail state by one edge.
    always_comb begin
        case (state_r)
            ST_UP:   dir_nxt_s = 2'b01;
            ST_DOWN: dir_nxt_s = 2'b10;
            default: dir_nxt_s = 2'b00;
        endcase
    end

    // State, service direction and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            svc_dir_r   <= SVC_NONE;
            dir_r       <= 2'b00;
            stop_here_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            svc_dir_r   <= svc_dir_nxt_s;
            dir_r       <= dir_nxt_s;
            stop_here_r <= (state_r == ST_SERVE);
        end
    end

    assign bus.dir       = dir_r;
    assign bus.stop_here = stop_here_r;
    assign bus.up_lamp   = up_req_r;
    assign bus.down_lamp = down_req_r;
    assign bus.in_lamp   = in_req_r;
endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: linear stimulus, hand-computed expectations.
module tb_call_scheduler;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    call_scheduler_if #(.FLOORS(4)) bus ();

    call_scheduler #(.FLOORS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.out_up = 3'b000; bus.out_down = 3'b000; bus.in_num = 4'b0000;
        bus.arrived = 1'b0; bus.served = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.out_up = 3'b111; bus.out_down = 3'b111; bus.in_num = 4'b1111;
        bus.floor = 4'b0001; bus.arrived = 1'b0; bus.served = 1'b0;

        // 1: reset with buttons held, then latch after release
        step(); step();
        chk("rst_up_lamp",   8'(bus.up_lamp),   8'h00);
        chk("rst_down_lamp", 8'(bus.down_lamp), 8'h00);
        chk("rst_in_lamp",   8'(bus.in_lamp),   8'h00);
        chk("rst_dir",       8'(bus.dir),       8'h00);
        chk("rst_stop",      8'(bus.stop_here), 8'h00);
        rst = 1'b0;
        step();
        chk("latch_up_lamp", 8'(bus.up_lamp),   8'h07);
        chk("latch_in_lamp", 8'(bus.in_lamp),   8'h0f);
        do_reset();
        chk("rst2_in_lamp",  8'(bus.in_lamp),   8'h00);

        // 2: call at current floor -> serve, clear, back to idle
        bus.floor = 4'b0001;
        bus.out_up = 3'b001;
        step();
        bus.out_up = 3'b000;
        chk("t2_up_lamp", 8'(bus.up_lamp), 8'h01);
        step();
        chk("t2_stop_early", 8'(bus.stop_here), 8'h00);
        step();
        chk("t2_stop", 8'(bus.stop_here), 8'h01);
        chk("t2_dir",  8'(bus.dir),       8'h00);
        bus.served = 1'b1;
        step();
        bus.served = 1'b0;
        chk("t2_up_clr", 8'(bus.up_lamp), 8'h00);
        step();
        chk("t2_stop_off", 8'(bus.stop_here), 8'h00);
        step();
        chk("t2_dir_idle", 8'(bus.dir), 8'h00);

        // 3: sweep up past a down call, serve top, reverse and serve down call
        do_reset();
        bus.floor = 4'b0001;
        bus.in_num = 4'b1000;
        step();
        bus.in_num = 4'b0000;
        step(); step();
        chk("t3_dir_up", 8'(bus.dir), 8'h01);
        bus.out_down = 3'b010;
        step();
        bus.out_down = 3'b000;
        chk("t3_down_lamp", 8'(bus.down_lamp), 8'h02);
        bus.floor = 4'b0100; bus.arrived = 1'b1;
        step();
        bus.arrived = 1'b0;
        step();
        chk("t3_pass_dir",  8'(bus.dir),       8'h01);
        chk("t3_pass_stop", 8'(bus.stop_here), 8'h00);
        bus.floor = 4'b1000; bus.arrived = 1'b1;
        step();
        bus.arrived = 1'b0;
        step();
        chk("t3_top_stop", 8'(bus.stop_here), 8'h01);
        chk("t3_top_dir",  8'(bus.dir),       8'h00);
        bus.served = 1'b1;
        step();
        bus.served = 1'b0;
        chk("t3_in_clr", 8'(bus.in_lamp), 8'h00);
        step(); step();
        chk("t3_dir_down", 8'(bus.dir), 8'h02);
        bus.floor = 4'b0100; bus.arrived = 1'b1;
        step();
        bus.arrived = 1'b0;
        step();
        chk("t3_f2_stop", 8'(bus.stop_here), 8'h01);
        bus.served = 1'b1;
        step();
        bus.served = 1'b0;
        chk("t3_down_clr", 8'(bus.down_lamp), 8'h00);
        step(); step();
        chk("t3_idle_dir",  8'(bus.dir),       8'h00);
        chk("t3_idle_stop", 8'(bus.stop_here), 8'h00);

        // 4: clear beats a held button only in the served cycle
        do_reset();
        bus.floor = 4'b0010;
        bus.out_up = 3'b010;
        step();
        bus.out_up = 3'b000;
        step(); step();
        chk("t4_stop", 8'(bus.stop_here), 8'h01);
        bus.out_up = 3'b010; bus.served = 1'b1;
        step();
        bus.served = 1'b0;
        chk("t4_clr_wins", 8'(bus.up_lamp), 8'h00);
        step();
        bus.out_up = 3'b000;
        chk("t4_reset_bit", 8'(bus.up_lamp), 8'h02);

        // 5: reset while moving discards everything
        do_reset();
        bus.floor = 4'b0001;
        bus.in_num = 4'b0100;
        step();
        bus.in_num = 4'b0000;
        step(); step();
        chk("t5_dir_up", 8'(bus.dir), 8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_in_lamp", 8'(bus.in_lamp), 8'h00);
        chk("t5_dir",     8'(bus.dir),     8'h00);

        // 6: invalid floor freezes the FSM but calls still latch
        do_reset();
        bus.floor = 4'b0000;
        bus.in_num = 4'b0010;
        step();
        bus.in_num = 4'b0000;
        chk("t6_in_lamp", 8'(bus.in_lamp), 8'h02);
        step(); step();
        chk("t6_dir_hold", 8'(bus.dir), 8'h00);
        bus.floor = 4'b0001;
        step(); step();
        chk("t6_dir_up", 8'(bus.dir), 8'h01);
        bus.floor = 4'b0000; bus.arrived = 1'b1;
        step();
        bus.arrived = 1'b0;
        step();
        chk("t6_up_hold", 8'(bus.dir),       8'h01);
        chk("t6_no_stop", 8'(bus.stop_here), 8'h00);
        bus.floor = 4'b0010; bus.arrived = 1'b1;
        step();
        bus.arrived = 1'b0;
        step();
        chk("t6_stop", 8'(bus.stop_here), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
